// File: rtl/ltl_nfa_pkg.sv
// Shared types for the runtime-programmable NFA monitor: config opcodes,
// start types and the report entry layout seen by the aggregator.
package ltl_nfa_pkg;

  typedef enum logic [1:0] {
    CFG_MATCH  = 2'd0,
    CFG_EDGE   = 2'd1,
    CFG_START  = 2'd2,
    CFG_REPORT = 2'd3
  } cfg_kind_e;

  typedef enum logic [1:0] {
    START_NONE = 2'd0,
    START_SOD  = 2'd1,
    START_ALL  = 2'd2
  } start_e;

  // Widest legal configuration; narrower engines zero-extend into this.
  localparam int MAX_STATES = 32;
  localparam int MAX_TS_W   = 64;

  typedef struct packed {
    logic [MAX_STATES-1:0] vec;
    logic [MAX_TS_W-1:0]   ts;
  } report_entry_t;

  function automatic report_entry_t build_entry(input logic [MAX_STATES-1:0] vec,
                                                input logic [MAX_TS_W-1:0]   ts);
    report_entry_t e;
    e.vec = vec;
    e.ts  = ts;
    return e;
  endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous report FIFO; a push into a full FIFO is accepted only when a
// pop frees the head slot in the same cycle, otherwise it is flagged as dropped.
module ltl_report_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         push_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_pop, do_push;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && full && !do_pop;
  assign pop_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ltl_nfa_engine.sv
// Homogeneous NFA monitor: per-state symbol bitmaps, adjacency matrix, start
// types and report enables are loaded at runtime; one symbol per step.
module ltl_nfa_engine
  import ltl_nfa_pkg::*;
#(
  parameter int NUM_STATES = 16,
  parameter int SYMBOL_W   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 32,
  localparam int SW = $clog2(NUM_STATES),
  localparam int AW = (SYMBOL_W > SW) ? SYMBOL_W : SW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  sym_valid,
  input  logic [SYMBOL_W-1:0]   symbols,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_kind,
  input  logic [SW-1:0]         cfg_state,
  input  logic [AW-1:0]         cfg_arg,
  input  logic [1:0]            cfg_data,
  output logic [NUM_STATES-1:0] active_vec,
  output logic                  report_valid,
  input  logic                  report_ready,
  output logic [NUM_STATES-1:0] report_vec,
  output logic [TS_W-1:0]       report_ts,
  output logic                  overflow
);
  localparam int NSYM = 1 << SYMBOL_W;

  logic [NUM_STATES-1:0][NSYM-1:0]       match_q;
  logic [NUM_STATES-1:0][NUM_STATES-1:0] edge_q;   // [src][dst]
  logic [NUM_STATES-1:0] start_sod, start_all, report_en;
  logic [NUM_STATES-1:0] enable, m, active_next, rep;
  logic [TS_W-1:0]       ts;
  logic                  first, step, push, push_drop, fifo_empty;
  logic [NUM_STATES+TS_W-1:0] head;
  cfg_kind_e             kind;
  logic                  cfg_wr, arg_sym_ok, arg_state_ok;

  assign kind         = cfg_kind_e'(cfg_kind);
  assign cfg_wr       = cfg_we && !run && (32'(cfg_state) < NUM_STATES);
  assign arg_sym_ok   = 32'(cfg_arg) < NSYM;
  assign arg_state_ok = 32'(cfg_arg) < NUM_STATES;

  always_ff @(posedge clk) begin
    if (reset) begin
      match_q   <= '0;
      edge_q    <= '0;
      start_sod <= '0;
      start_all <= '0;
      report_en <= '0;
    end else if (cfg_wr) begin
      case (kind)
        CFG_MATCH:  if (arg_sym_ok) match_q[cfg_state][cfg_arg[SYMBOL_W-1:0]] <= cfg_data[0];
        CFG_EDGE:   if (arg_state_ok) edge_q[cfg_arg[SW-1:0]][cfg_state] <= cfg_data[0];
        CFG_START: begin
          start_sod[cfg_state] <= (cfg_data == START_SOD);
          start_all[cfg_state] <= (cfg_data == START_ALL);
        end
        CFG_REPORT: report_en[cfg_state] <= cfg_data[0];
        default: ;
      endcase
    end
  end

  // Every active state fans its adjacency row into the successors' enables.
  always_comb begin
    enable = start_all | (start_sod & {NUM_STATES{first}});
    for (int i = 0; i < NUM_STATES; i++)
      if (active_vec[i]) enable = enable | edge_q[i];
    for (int j = 0; j < NUM_STATES; j++)
      m[j] = match_q[j][symbols];
    active_next = m & enable;
  end

  assign step = run && sym_valid;
  assign rep  = active_next & report_en;
  assign push = step && (|rep);

  always_ff @(posedge clk) begin
    if (reset) begin
      active_vec <= '0;
      ts         <= '0;
      first      <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (step) begin
        active_vec <= active_next;
        ts         <= ts + 1'b1;
        first      <= 1'b0;
      end
      if (push_drop) overflow <= 1'b1;
    end
  end

  ltl_report_fifo #(.DEPTH(FIFO_DEPTH), .W(NUM_STATES + TS_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({rep, ts}),
    .pop       (report_ready),
    .pop_data  (head),
    .full      (),
    .empty     (fifo_empty),
    .push_drop (push_drop)
  );

  assign report_valid = !fifo_empty;
  assign report_vec   = head[NUM_STATES+TS_W-1:TS_W];
  assign report_ts    = head[TS_W-1:0];

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// Scoreboarded bench: a set-level NFA model predicts reports; a monitor pops
// and compares whenever the DUT hands an entry to the consumer.
module tb_ltl_nfa_engine;
  import ltl_nfa_pkg::*;

  localparam int NS = 16, SYW = 8, FD = 8, TSW = 32, NSYM = 256;

  logic          clk = 1'b0;
  logic          reset, run, sym_valid, cfg_we, report_ready;
  logic [7:0]    symbols, cfg_arg;
  logic [1:0]    cfg_kind, cfg_data;
  logic [3:0]    cfg_state;
  logic [15:0]   active_vec, report_vec;
  logic          report_valid, overflow;
  logic [31:0]   report_ts;

  always #5 clk = ~clk;

  ltl_nfa_engine #(.NUM_STATES(NS), .SYMBOL_W(SYW), .FIFO_DEPTH(FD), .TS_W(TSW)) dut (
    .clk(clk), .reset(reset), .run(run), .sym_valid(sym_valid), .symbols(symbols),
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_state(cfg_state), .cfg_arg(cfg_arg),
    .cfg_data(cfg_data), .active_vec(active_vec), .report_valid(report_valid),
    .report_ready(report_ready), .report_vec(report_vec), .report_ts(report_ts),
    .overflow(overflow)
  );

  // reference model: the automaton as plain tables and a set of active states
  bit            mm [NS][NSYM];
  bit            me [NS][NS];      // [src][dst]
  int            ms [NS];
  bit            mr [NS];
  bit            ma [NS];
  bit            mfirst, movf;
  longint unsigned mts;
  int            mcnt;
  report_entry_t exp_q[$];
  report_entry_t mon_e;
  int            total = 0, bad = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_active();
    logic [15:0] v;
    for (int j = 0; j < NS; j++) v[j] = ma[j];
    return v;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < NS; j++) begin
      for (int s = 0; s < NSYM; s++) mm[j][s] = 0;
      for (int i = 0; i < NS; i++) me[j][i] = 0;
      ms[j] = 0; mr[j] = 0; ma[j] = 0;
    end
    mfirst = 1; movf = 0; mts = 0; mcnt = 0;
    exp_q.delete();
  endfunction

  // one clock cycle of stimulus; called just after a negedge
  task automatic cyc(input bit r, input bit sv, input int sym, input bit we, input int kind,
                     input int st, input int arg, input int data, input bit rdy);
    bit nxt [NS];
    logic [15:0] repv;
    bit pop_m, acc;
    run = r; sym_valid = sv; symbols = 8'(sym); cfg_we = we; cfg_kind = 2'(kind);
    cfg_state = 4'(st); cfg_arg = 8'(arg); cfg_data = 2'(data); report_ready = rdy;
    pop_m = (mcnt > 0) && rdy;
    acc = 0;
    if (r && sv) begin
      repv = '0;
      for (int j = 0; j < NS; j++) begin
        bit en;
        en = (ms[j] == 2) || (ms[j] == 1 && mfirst);
        for (int i = 0; i < NS; i++) if (ma[i] && me[i][j]) en = 1;
        nxt[j] = en && mm[j][sym];
        repv[j] = nxt[j] && mr[j];
      end
      if (repv != 0) begin
        if (mcnt < FD || pop_m) begin
          exp_q.push_back(build_entry(32'(repv), mts));
          acc = 1;
        end else movf = 1;
      end
      for (int j = 0; j < NS; j++) ma[j] = nxt[j];
      mts = (mts + 1) % 64'h1_0000_0000;
      mfirst = 0;
    end
    if (we && !r) begin
      case (kind)
        0: if (arg < NSYM) mm[st][arg] = data[0];
        1: if (arg < NS) me[arg][st] = data[0];
        2: ms[st] = data;
        default: mr[st] = data[0];
      endcase
    end
    mcnt = mcnt - int'(pop_m) + int'(acc);
    @(posedge clk); #1;
    chk("active_vec", active_vec, model_active());
    chk("report_valid", report_valid, mcnt > 0);
    chk("overflow", overflow, movf);
    @(negedge clk);
  endtask

  task automatic wcfg(input int kind, input int st, input int arg, input int data);
    cyc(0, 0, 0, 1, kind, st, arg, data, 0);
  endtask
  task automatic feed(input int sym, input bit rdy);
    cyc(1, 1, sym, 0, 0, 0, 0, 0, rdy);
  endtask
  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic rst();
    reset = 1; run = 0; sym_valid = 0; cfg_we = 0; report_ready = 1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_active", active_vec, 0);
    chk("rst_valid", report_valid, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic prog1(input int start);
    wcfg(2, 0, 0, start);
    for (int s = 0; s < 16; s++) wcfg(0, 0, s, 1);
    wcfg(0, 1, 16, 1);
    wcfg(1, 1, 0, 1);
    wcfg(3, 1, 0, 1);
  endtask

  task automatic loop2();
    wcfg(2, 2, 0, 2);
    for (int s = 0; s < NSYM; s++) wcfg(0, 2, s, 1);
    wcfg(1, 2, 2, 1);
    wcfg(3, 2, 0, 1);
  endtask

  always @(posedge clk) begin
    if (!reset && report_valid && report_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_unexpected: got vec=%0h ts=%0h expected none", report_vec, report_ts);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_vec", report_vec, mon_e.vec);
        chk("pop_ts", report_ts, mon_e.ts);
      end
    end
  end

  initial begin
    reset = 1; run = 0; sym_valid = 0; symbols = 0; cfg_we = 0; cfg_kind = 0;
    cfg_state = 0; cfg_arg = 0; cfg_data = 0; report_ready = 0;
    @(negedge clk);
    rst();

    // start-of-data chain 0 -> 1
    prog1(1);
    feed(8'h05, 1);
    feed(8'h10, 0);
    chk("t1_valid", report_valid, 1);
    chk("t1_vec", report_vec, 16'h0002);
    chk("t1_ts", report_ts, 1);
    idle(1);

    // start_of_data only arms the first symbol; START_ALL re-arms every step
    rst(); prog1(1);
    feed(8'h20, 1); feed(8'h05, 1); feed(8'h10, 1);
    chk("t2_none", report_valid, 0);
    rst(); prog1(2);
    feed(8'h20, 0); feed(8'h05, 0); feed(8'h10, 0);
    chk("t2_vec", report_vec, 16'h0002);
    chk("t2_ts", report_ts, 2);
    idle(1);

    // fill to overflow, then drain in order
    rst(); loop2();
    for (int k = 0; k < 9; k++) feed($urandom_range(0, 255), 0);
    chk("t3_ovf", overflow, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t3_order", report_ts, k);
      idle(1);
    end
    chk("t3_empty", report_valid, 0);

    // full plus simultaneous pop and push
    rst(); loop2();
    for (int k = 0; k < 8; k++) feed($urandom_range(0, 255), 0);
    feed(8'h77, 1);
    chk("t4_ovf", overflow, 0);
    for (int k = 1; k < 9; k++) begin
      chk("t4_order", report_ts, k);
      idle(1);
    end

    // config writes while running are ignored
    rst();
    wcfg(2, 3, 0, 2); wcfg(0, 3, 8'h33, 1);
    cyc(1, 1, 8'h33, 1, 3, 3, 0, 1, 1);
    chk("t5_ignored", report_valid, 0);
    chk("t5_active", active_vec, 16'h0008);
    wcfg(3, 3, 0, 1);
    feed(8'h33, 0);
    chk("t5_vec", report_vec, 16'h0008);
    idle(1);

    // reset mid-operation clears everything, including config
    rst(); loop2();
    wcfg(2, 1, 0, 2); wcfg(0, 1, 8'h44, 1);
    for (int k = 0; k < 3; k++) feed(8'h44, 0);
    chk("t6_active", active_vec, 16'h0006);
    rst();
    for (int k = 0; k < 5; k++) feed($urandom_range(0, 255), 1);
    chk("t6_quiet", report_valid, 0);

    // randomized programs and traces over a small alphabet
    for (int round = 0; round < 4; round++) begin
      rst();
      for (int k = 0; k < 120; k++) begin
        int kd;
        kd = $urandom_range(0, 3);
        wcfg(kd, $urandom_range(0, NS-1),
             (kd == 0) ? $urandom_range(0, 9) : $urandom_range(0, 19),
             $urandom_range(0, 3));
      end
      for (int k = 0; k < 150; k++)
        cyc($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, NS-1),
            $urandom_range(0, 7), 1, $urandom_range(0, 2) == 0);
    end
    for (int k = 0; k < FD + 2; k++) idle(1);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
